// File: rtl/regfile_mp_pkg.sv
// Core-wide constants shared by the register file and its scoreboard.
package regfile_mp_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = 0;

endpackage : regfile_mp_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reserve sets, completed write clears, flush wipes all.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [(2**ADDR_WIDTH)-1:0]   wr_clr,
    input  logic                         resv_en,
    input  logic [ADDR_WIDTH-1:0]        resv_addr,
    input  logic                         flush,
    output logic [(2**ADDR_WIDTH)-1:0]   busy,
    output logic                         resv_ok
);

    localparam int unsigned NENT = 2 ** ADDR_WIDTH;

    logic [NENT-1:0] busy_q;
    logic [NENT-1:0] busy_d;

    // Reserve is judged against current busy only; same-cycle clears do not help.
    assign resv_ok = resv_en & ~busy_q[resv_addr];
    assign busy    = busy_q;

    always_comb begin
        busy_d = busy_q & ~wr_clr;
        if (resv_ok && (resv_addr != ADDR_WIDTH'(ZERO_REG))) begin
            busy_d[resv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0, write forwarding and busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic                           resv_en,
    input  logic [ADDR_WIDTH-1:0]          resv_addr,
    output logic                           resv_ok,
    input  logic                           flush
);

    localparam int unsigned NENT = 2 ** ADDR_WIDTH;

    // Plain module-level array so difftest can peek at architectural state.
    logic [DATA_WIDTH-1:0] regs_q [NENT];
    logic [NENT-1:0]       wr_mask;
    logic [NENT-1:0]       busy;
    logic                  byp_en;

    assign byp_en = (BYPASS != 0) && rst;

    always_comb begin
        wr_mask = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wen[p] && (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_REG))) begin
                wr_mask[waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    // Later ports are applied last, so the highest-index port wins on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NENT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wen[p] && (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_REG))) begin
                    regs_q[waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            rdata[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[raddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            rbusy[r]                          = busy[raddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (byp_en && wen[p]
                    && (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == raddr[r*ADDR_WIDTH +: ADDR_WIDTH])
                    && (raddr[r*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_REG))) begin
                    rdata[r*DATA_WIDTH +: DATA_WIDTH] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
                    rbusy[r]                          = 1'b0;
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_clr    (wr_mask),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .flush     (flush),
        .busy      (busy),
        .resv_ok   (resv_ok)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding instance on shared stimulus.
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    wen;
    logic [2*AW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic          resv_en;
    logic [AW-1:0] resv_addr;
    logic          flush;

    logic [2*DW-1:0] rdata_b, rdata_n;
    logic [1:0]      rbusy_b, rbusy_n;
    logic            resv_ok_b, resv_ok_n;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_ok(resv_ok_b), .flush(flush)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_ok(resv_ok_n), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; raddr = '0;
        resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[p] = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic set_resv(input logic [AW-1:0] a);
        resv_en = 1'b1;
        resv_addr = a;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_wr(0, 5'd5, 32'h0000CAFE); set_rd(0, 5'd5); set_rd(1, 5'd9); set_resv(5'd9);
        #1;
        checks++; if (rdata_b !== 64'h0) begin failures++; $display("FAIL rst_rdata_byp got=%h exp=%h", rdata_b, 64'h0); end
        checks++; if (rdata_n !== 64'h0) begin failures++; $display("FAIL rst_rdata_nb got=%h exp=%h", rdata_n, 64'h0); end
        checks++; if (rbusy_b !== 2'b00) begin failures++; $display("FAIL rst_rbusy got=%b exp=%b", rbusy_b, 2'b00); end
        checks++; if (resv_ok_b !== 1'b1) begin failures++; $display("FAIL rst_resv_ok got=%b exp=%b", resv_ok_b, 1'b1); end
        @(negedge clk);
        rst = 1'b1; idle();
        @(negedge clk);
        set_rd(0, 5'd5); set_rd(1, 5'd9);
        #1;
        checks++; if (rbusy_n !== 2'b00) begin failures++; $display("FAIL rst_no_resv got=%b exp=%b", rbusy_n, 2'b00); end
        checks++; if (rdata_n !== 64'h0) begin failures++; $display("FAIL rst_no_write got=%h exp=%h", rdata_n, 64'h0); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle(); set_wr(0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        idle(); set_rd(0, 5'd5); set_rd(1, 5'd5);
        #1;
        checks++; if (rdata_n !== {2{32'hDEADBEEF}}) begin failures++; $display("FAIL wr_rd_both got=%h exp=%h", rdata_n, {2{32'hDEADBEEF}}); end
        checks++; if (rbusy_n !== 2'b00) begin failures++; $display("FAIL wr_rd_busy got=%b exp=%b", rbusy_n, 2'b00); end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22);
        @(negedge clk);
        idle(); set_wr(0, 5'd0, 32'h55); set_rd(0, 5'd0); set_rd(1, 5'd7);
        #1;
        checks++; if (rdata_b[31:0] !== 32'h0) begin failures++; $display("FAIL x0_no_bypass got=%h exp=%h", rdata_b[31:0], 32'h0); end
        checks++; if (rdata_n[63:32] !== 32'h22) begin failures++; $display("FAIL wr_collision got=%h exp=%h", rdata_n[63:32], 32'h22); end
        @(negedge clk);
        idle(); set_rd(0, 5'd0); set_rd(1, 5'd0);
        #1;
        checks++; if (rdata_n !== 64'h0) begin failures++; $display("FAIL x0_read got=%h exp=%h", rdata_n, 64'h0); end
        checks++; if (rbusy_n !== 2'b00) begin failures++; $display("FAIL x0_busy got=%b exp=%b", rbusy_n, 2'b00); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle(); set_wr(0, 5'd3, 32'h77);
        @(negedge clk);
        idle(); set_wr(0, 5'd3, 32'hA5); set_rd(0, 5'd3);
        #1;
        checks++; if (rdata_b[31:0] !== 32'hA5) begin failures++; $display("FAIL byp_data got=%h exp=%h", rdata_b[31:0], 32'hA5); end
        checks++; if (rdata_n[31:0] !== 32'h77) begin failures++; $display("FAIL nobyp_old got=%h exp=%h", rdata_n[31:0], 32'h77); end
        @(negedge clk);
        idle(); set_wr(0, 5'd3, 32'h1); set_wr(1, 5'd3, 32'h2); set_rd(0, 5'd3); set_rd(1, 5'd3);
        #1;
        checks++; if (rdata_n[31:0] !== 32'hA5) begin failures++; $display("FAIL nobyp_new got=%h exp=%h", rdata_n[31:0], 32'hA5); end
        checks++; if (rdata_b !== {2{32'h2}}) begin failures++; $display("FAIL byp_winner got=%h exp=%h", rdata_b, {2{32'h2}}); end
        @(negedge clk);
        idle(); set_rd(0, 5'd3);
        #1;
        checks++; if (rdata_n[31:0] !== 32'h2) begin failures++; $display("FAIL collide_store got=%h exp=%h", rdata_n[31:0], 32'h2); end
    endtask

    task automatic test_reserve();
        @(negedge clk);
        idle(); set_resv(5'd9);
        #1;
        checks++; if (resv_ok_b !== 1'b1) begin failures++; $display("FAIL resv_first got=%b exp=%b", resv_ok_b, 1'b1); end
        @(negedge clk);
        idle(); set_resv(5'd9); set_rd(0, 5'd9);
        #1;
        checks++; if (rbusy_b[0] !== 1'b1) begin failures++; $display("FAIL resv_busy got=%b exp=%b", rbusy_b[0], 1'b1); end
        checks++; if (resv_ok_b !== 1'b0) begin failures++; $display("FAIL resv_waw got=%b exp=%b", resv_ok_b, 1'b0); end
        @(negedge clk);
        idle(); set_wr(0, 5'd9, 32'h99); set_rd(0, 5'd9);
        #1;
        checks++; if (rbusy_b[0] !== 1'b0) begin failures++; $display("FAIL byp_busy got=%b exp=%b", rbusy_b[0], 1'b0); end
        checks++; if (rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL nobyp_busy got=%b exp=%b", rbusy_n[0], 1'b1); end
        @(negedge clk);
        idle(); set_rd(0, 5'd9); set_resv(5'd9); set_wr(0, 5'd9, 32'h100);
        #1;
        checks++; if (rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL wr_clears got=%b exp=%b", rbusy_n[0], 1'b0); end
        checks++; if (resv_ok_b !== 1'b1) begin failures++; $display("FAIL resv_wr_ok got=%b exp=%b", resv_ok_b, 1'b1); end
        @(negedge clk);
        idle(); set_rd(0, 5'd9); set_resv(5'd9); set_wr(1, 5'd9, 32'h200);
        #1;
        checks++; if (rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL resv_wins got=%b exp=%b", rbusy_n[0], 1'b1); end
        checks++; if (rdata_n[31:0] !== 32'h100) begin failures++; $display("FAIL resv_wr_data got=%h exp=%h", rdata_n[31:0], 32'h100); end
        checks++; if (resv_ok_b !== 1'b0) begin failures++; $display("FAIL no_resv_bypass got=%b exp=%b", resv_ok_b, 1'b0); end
        @(negedge clk);
        idle(); set_rd(0, 5'd9); set_resv(5'd0);
        #1;
        checks++; if (rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL rejected_resv got=%b exp=%b", rbusy_n[0], 1'b0); end
        checks++; if (rdata_n[31:0] !== 32'h200) begin failures++; $display("FAIL port1_wr got=%h exp=%h", rdata_n[31:0], 32'h200); end
        checks++; if (resv_ok_b !== 1'b1) begin failures++; $display("FAIL resv_x0 got=%b exp=%b", resv_ok_b, 1'b1); end
        @(negedge clk);
        idle(); set_rd(0, 5'd0);
        #1;
        checks++; if (rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL x0_never_busy got=%b exp=%b", rbusy_n[0], 1'b0); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        idle(); set_resv(5'd4);
        @(negedge clk);
        idle(); set_resv(5'd6);
        @(negedge clk);
        idle(); set_rd(0, 5'd4); set_rd(1, 5'd6);
        flush = 1'b1; set_resv(5'd8); set_wr(1, 5'd10, 32'hAB);
        #1;
        checks++; if (rbusy_n !== 2'b11) begin failures++; $display("FAIL pre_flush got=%b exp=%b", rbusy_n, 2'b11); end
        checks++; if (resv_ok_b !== 1'b1) begin failures++; $display("FAIL flush_resv_ok got=%b exp=%b", resv_ok_b, 1'b1); end
        @(negedge clk);
        idle(); set_rd(0, 5'd4); set_rd(1, 5'd6);
        #1;
        checks++; if (rbusy_n !== 2'b00) begin failures++; $display("FAIL post_flush got=%b exp=%b", rbusy_n, 2'b00); end
        @(negedge clk);
        idle(); set_rd(0, 5'd8); set_rd(1, 5'd10);
        #1;
        checks++; if (rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL flush_x8 got=%b exp=%b", rbusy_n[0], 1'b0); end
        checks++; if (rdata_n[63:32] !== 32'hAB) begin failures++; $display("FAIL flush_wr got=%h exp=%h", rdata_n[63:32], 32'hAB); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle(); set_wr(0, 5'd5, 32'h1234); set_resv(5'd5);
        @(negedge clk);
        idle(); set_rd(0, 5'd5); set_rd(1, 5'd5);
        #1;
        checks++; if (rdata_n !== {2{32'h1234}}) begin failures++; $display("FAIL pre_arst_data got=%h exp=%h", rdata_n, {2{32'h1234}}); end
        checks++; if (rbusy_n !== 2'b11) begin failures++; $display("FAIL pre_arst_busy got=%b exp=%b", rbusy_n, 2'b11); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rdata_b !== 64'h0) begin failures++; $display("FAIL arst_data got=%h exp=%h", rdata_b, 64'h0); end
        checks++; if (rbusy_b !== 2'b00) begin failures++; $display("FAIL arst_busy got=%b exp=%b", rbusy_b, 2'b00); end
        checks++; if (rdata_n !== 64'h0) begin failures++; $display("FAIL arst_data_nb got=%h exp=%h", rdata_n, 64'h0); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rdata_n !== 64'h0) begin failures++; $display("FAIL post_arst got=%h exp=%h", rdata_n, 64'h0); end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_same_addr();
        test_bypass();
        test_reserve();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_mp
